// File: rtl/div_cu_pkg.sv
// Shared definitions for the SRT radix-2 divider control unit.
// Holds the controller state encoding and the adder/quotient mux codes
// that the datapath decodes on its leftAddMux_sel, rightAddMux_sel and
// QCorrectBitMux_sel pins.
package div_cu_pkg;

    // Controller phases, in the order a normal division walks them.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_NORM,
        S_COMPL,
        S_ITER,
        S_LAST,
        S_RCORR,
        S_LDCNT,
        S_DENORM,
        S_DONE
    } state_t;

    // Left adder operand select (remainder side).
    localparam logic [1:0] ADD_CS   = 2'b00; // sum + carry
    localparam logic [1:0] ADD_NOTD = 2'b01; // ~D (+1 via mode)
    localparam logic [1:0] ADD_D    = 2'b10; // R + D
    localparam logic [1:0] ADD_ND   = 2'b11; // R - D

    // Right adder operand select (quotient side).
    localparam logic [1:0] Q_CONV = 2'b00; // Q - NQ conversion
    localparam logic [1:0] Q_CORR = 2'b01; // +/-1 correction
    localparam logic [1:0] Q_NOT  = 2'b10;

    // Quotient correction bit select.
    localparam logic QCB_INC = 1'b0; // Q + 1
    localparam logic QCB_DEC = 1'b1; // Q - 1

    // The divisor is normalised once the two bits below its sign differ.
    function automatic logic is_normalised(input logic [1:0] mag);
        return mag[1] ^ mag[0];
    endfunction

endpackage

// File: rtl/div_cu_iter_counter.sv
// Local iteration counter of the divider control unit.
// Ports: clk, rst (async high), clear, inc -> terminal (count == TERM).
module div_cu_iter_counter #(
    parameter int           W    = 6,
    parameter logic [W-1:0] TERM = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TERM);

endmodule

// File: rtl/divisor_unit_cu.sv
// Sequencing controller for the carry-save SRT radix-2 divider datapath.
// Ports: clk, rst, start/busy/done/dbz handshake, dividend_msb plus the
// datapath status lines (tc, signS, magnitudeD) in, and every datapath
// enable/select out. Controls are decoded from the registered state;
// status lines only steer them in NORM, RCORR and DENORM.
module divisor_unit_cu
    import div_cu_pkg::*;
#(
    parameter int PARALLELISM = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dividend_msb,
    input  logic       tc,
    input  logic       signS,
    input  logic [1:0] magnitudeD,
    output logic       busy,
    output logic       done,
    output logic       dbz,
    output logic       csa_clear,
    output logic       divisor_en,
    output logic       divisor_lShift,
    output logic       notDivisor_en,
    output logic       saveReminder,
    output logic       sumHMux_sel,
    output logic       sum_en,
    output logic       carry_en,
    output logic [1:0] leftAddMux_sel,
    output logic [1:0] rightAddMux_sel,
    output logic       QCorrectBitMux_sel,
    output logic       leftAddMode,
    output logic       rightAddMode,
    output logic       reminder_en,
    output logic       reminder_rShift,
    output logic       quotient_en,
    output logic       counterMux_sel,
    output logic       count_upDown,
    output logic       count_load,
    output logic       count_en,
    output logic       counterReg_en
);

    state_t state;
    state_t state_next;

    logic cnt_clear;
    logic cnt_inc;
    logic cnt_term;
    logic normalised;

    assign normalised = is_normalised(magnitudeD);

    div_cu_iter_counter #(
        .W    (CNT_W),
        .TERM (CNT_W'(PARALLELISM - 1))
    ) u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .terminal (cnt_term)
    );

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = S_CLR;
            S_CLR:    state_next = S_LOAD;
            S_LOAD:   state_next = S_NORM;
            S_NORM: begin
                if (normalised) begin
                    state_next = S_COMPL;
                end else if (cnt_term) begin
                    // Never normalised within the operand width: D == 0.
                    state_next = S_DONE;
                end
            end
            S_COMPL:  state_next = S_ITER;
            S_ITER:   if (cnt_term) state_next = S_LAST;
            S_LAST:   state_next = S_RCORR;
            S_RCORR:  state_next = S_LDCNT;
            S_LDCNT:  state_next = S_DENORM;
            S_DENORM: if (tc) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register and the handshake outputs, which are registered
    // copies of where the FSM is heading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_DONE);
            if (state == S_LOAD) begin
                dbz <= 1'b0;
            end else if (state == S_NORM && !normalised && cnt_term) begin
                dbz <= 1'b1;
            end
        end
    end

    // Datapath control decode.
    always_comb begin
        csa_clear          = 1'b0;
        divisor_en         = 1'b0;
        divisor_lShift     = 1'b0;
        notDivisor_en      = 1'b0;
        saveReminder       = 1'b0;
        sumHMux_sel        = 1'b0;
        sum_en             = 1'b0;
        carry_en           = 1'b0;
        leftAddMux_sel     = ADD_CS;
        rightAddMux_sel    = Q_CONV;
        QCorrectBitMux_sel = QCB_INC;
        leftAddMode        = 1'b0;
        rightAddMode       = 1'b0;
        reminder_en        = 1'b0;
        reminder_rShift    = 1'b0;
        quotient_en        = 1'b0;
        counterMux_sel     = 1'b0;
        count_upDown       = 1'b0;
        count_load         = 1'b0;
        count_en           = 1'b0;
        counterReg_en      = 1'b0;
        cnt_clear          = 1'b0;
        cnt_inc            = 1'b0;
        unique case (state)
            S_CLR: begin
                csa_clear = 1'b1;
            end
            S_LOAD: begin
                divisor_en     = 1'b1;
                sum_en         = 1'b1;
                sumHMux_sel    = 1'b0;
                // Datapath counter starts at 1 so the saved value is
                // shifts + 1 and DENORM can count down to tc.
                count_load     = 1'b1;
                counterMux_sel = 1'b0;
                cnt_clear      = 1'b1;
            end
            S_NORM: begin
                if (normalised) begin
                    counterReg_en = 1'b1;
                end else if (!cnt_term) begin
                    divisor_lShift = 1'b1;
                    count_en       = 1'b1;
                    count_upDown   = 1'b1;
                    cnt_inc        = 1'b1;
                end
            end
            S_COMPL: begin
                // ~D + 1: the two's complement used by the iterations.
                leftAddMux_sel = ADD_NOTD;
                leftAddMode    = 1'b1;
                notDivisor_en  = 1'b1;
                cnt_clear      = 1'b1;
            end
            S_ITER: begin
                sumHMux_sel = 1'b1;
                sum_en      = 1'b1;
                carry_en    = 1'b1;
                cnt_inc     = 1'b1;
            end
            S_LAST: begin
                saveReminder    = 1'b1;
                leftAddMux_sel  = ADD_CS;
                leftAddMode     = 1'b0;
                reminder_en     = 1'b1;
                rightAddMux_sel = Q_CONV;
                rightAddMode    = 1'b1;
                quotient_en     = 1'b1;
            end
            S_RCORR: begin
                // Remainder sign must match the dividend sign.
                if (signS && !dividend_msb) begin
                    leftAddMux_sel     = ADD_D;
                    leftAddMode        = 1'b0;
                    reminder_en        = 1'b1;
                    rightAddMux_sel    = Q_CORR;
                    QCorrectBitMux_sel = QCB_DEC;
                    rightAddMode       = 1'b0;
                    quotient_en        = 1'b1;
                end else if (!signS && dividend_msb) begin
                    leftAddMux_sel     = ADD_ND;
                    reminder_en        = 1'b1;
                    rightAddMux_sel    = Q_CORR;
                    QCorrectBitMux_sel = QCB_INC;
                    quotient_en        = 1'b1;
                end
            end
            S_LDCNT: begin
                count_load     = 1'b1;
                counterMux_sel = 1'b1;
            end
            S_DENORM: begin
                if (!tc) begin
                    reminder_rShift = 1'b1;
                    count_en        = 1'b1;
                    count_upDown    = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/divisor_unit_cu.md
# divisor_unit_cu

Sequencing controller for the carry-save SRT radix-2 divider datapath. It accepts a start request and steps the datapath through these phases: clear, operand load, divisor normalisation, divisor complement, `PARALLELISM` quotient iterations, final conversion, sign correction and remainder denormalisation. It sits between the multiply/divide top-level (start/done handshake) and the datapath control pins. It drives every datapath enable and select, and consumes the datapath status lines `tc`, `signS` and `magnitudeD`.

## Interface
- `PARALLELISM`, 32, operand width; iteration count.
- `CNT_W`, 6, width of the local iteration counter; must satisfy 2^CNT_W > PARALLELISM.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend_msb`  in  1  sign of the dividend; 0 when the operation is unsigned; must be stable while busy.
- `tc`, `signS`  in  1  datapath counter terminal count; datapath remainder sign.
- `magnitudeD`  in  2  the two MSBs below the sign of the divisor register.
- `busy`  out  1  high from the cycle after start is accepted until DONE, inclusive.
- `done`  out  1  one-cycle pulse; the results are valid while it is high.
- `dbz`  out  1  divide-by-zero; valid together with `done`.
- Datapath controls (out): `csa_clear`, `divisor_en`, `divisor_lShift`, `notDivisor_en`, `saveReminder`, `sumHMux_sel`, `sum_en`, `carry_en`, `leftAddMux_sel[1:0]`, `rightAddMux_sel[1:0]`, `QCorrectBitMux_sel`, `leftAddMode`, `rightAddMode`, `reminder_en`, `reminder_rShift`, `quotient_en`, `counterMux_sel`, `count_upDown` (1 = up), `count_load`, `count_en`, `counterReg_en`.

## Operation
- Moore FSM. Every control is 0 unless the state listed below asserts it.
- IDLE: start=1 → CLR.
- CLR: `csa_clear` → LOAD.
- LOAD:
  - `divisor_en`, `sum_en` with `sumHMux_sel`=0.
  - `count_load` with `counterMux_sel`=0, which loads the datapath counter with 1.
  - Local iteration counter ← 0, `dbz` ← 0. Next state NORM.
- NORM:
  - If `magnitudeD[1]`≠`magnitudeD[0]` (normalised): `counterReg_en` → COMPL.
  - Otherwise, if the local counter = PARALLELISM-1: `dbz` ← 1 → DONE.
  - Otherwise: `divisor_lShift`, `count_en`, `count_upDown`=1, local counter +1.
  - The saved count is therefore shifts+1.
- COMPL: `leftAddMux_sel`=01, `leftAddMode`=1 (~D+1 → two's complement), `notDivisor_en`. Local counter ← 0 → ITER.
- ITER:
  - `sumHMux_sel`=1, `sum_en`, `carry_en`, local counter +1.
  - When the counter = PARALLELISM-1, go to LAST instead, so there are exactly PARALLELISM ITER cycles.
- LAST:
  - `saveReminder`.
  - `leftAddMux_sel`=00, `leftAddMode`=0, `reminder_en`: the remainder becomes sum + carry.
  - `rightAddMux_sel`=00, `rightAddMode`=1, `quotient_en`: the quotient becomes Q−NQ.
  - Next state RCORR.
- RCORR, using `signS` from the register written in LAST:
  - `signS`=1 and `dividend_msb`=0:
    - `leftAddMux_sel`=10, `leftAddMode`=0 (R+D), `reminder_en`.
    - `rightAddMux_sel`=01, `QCorrectBitMux_sel`=1, `rightAddMode`=0 (Q−1), `quotient_en`.
  - `signS`=0 and `dividend_msb`=1:
    - `leftAddMux_sel`=11 (R−D), `reminder_en`.
    - `rightAddMux_sel`=01, `QCorrectBitMux_sel`=0 (Q+1), `quotient_en`.
  - Otherwise: no enables.
  - Next state LDCNT.
- LDCNT: `count_load`, `counterMux_sel`=1 (reload the saved count) → DENORM.
- DENORM:
  - `tc`=0: `reminder_rShift`, `count_en`, `count_upDown`=0.
  - `tc`=1: → DONE.
- DONE: `done` → IDLE.
- `start` outside IDLE is ignored. Do not queue it.

## Timing
- Reset (async, immediate): state IDLE. Every output, including `busy`, `done`, `dbz`, is 0. The local counter is 0.
- Reset mid-operation aborts the operation. Datapath registers keep stale contents. The next operation starts from CLR.
- Let k be the number of normalisation shifts.
- Latency, from the start-sampling edge to the `done` cycle: PARALLELISM+9+2k cycles. PARALLELISM=32, k=0 gives 41.
- Divide-by-zero latency: PARALLELISM+3 cycles. The quotient and remainder are undefined.
- `done` and `busy` are high together in DONE. start may be asserted in the cycle after DONE and is accepted.
- Controls are registered-state decoded only. They have no combinational path from `start`. Status inputs may affect controls combinationally only in NORM, RCORR and DENORM.

## Structure
- Shared package `div_cu_pkg`:
  - The state enum.
  - The `leftAddMux_sel` encodings: ADD_CS=00, ADD_NOTD=01, ADD_D=10, ADD_ND=11.
  - The `rightAddMux_sel` encodings: Q_CONV=00, Q_CORR=01, Q_NOT=10.
  - The QCorrectBit encodings.
- One sub-module, `div_cu_iter_counter`: the CNT_W local counter with clear, increment and equals-terminal flag.

## Test plan
- Unsigned 100÷7 (`dividend_msb`=0) → quotient 14, remainder 2. `done` is exactly one cycle. `dbz`=0.
- Signed −7÷2 (`dividend_msb`=1) → quotient −3 (0xFFFFFFFD), remainder −1. RCORR takes the Q+1/R−D branch when the raw remainder is positive.
- Signed 7÷−2 → quotient −3, remainder 1. Check that the `done` cycle count equals 41+2k for the observed k.
- Divisor 0 → `dbz`=1 with `done` exactly PARALLELISM+3 cycles after start. No `quotient_en` pulse occurs.
- start held high throughout an operation → only one operation. Exactly PARALLELISM `sum_en` cycles with `sumHMux_sel`=1.
- `rst` pulsed during ITER → all outputs 0 in the same cycle. A subsequent 100÷7 still yields 14 r 2.
